// File: rtl/apb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_mem_bridge
// Description : CPU-side APB master for the PSRAM APB slave. Takes one
//               load/store at a time, runs SETUP/ACCESS, waits for pready
//               (with optional timeout), masks read data by access size and
//               returns the result on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // CPU request port
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    // CPU response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // APB master port
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic                  pready,
    input  logic                  perr
);

    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [1:0]              size_q;
    logic [TW-1:0]           tmo_cnt_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [3:0]              pstb_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pdata_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;

    logic [DATA_WIDTH-1:0]   rd_mask;
    logic [3:0]              req_stb;
    logic                    tmo_hit;

    // Read-data lane mask for the latched access size
    always_comb begin
        rd_mask = '0;
        case (size_q)
            2'd0:    rd_mask = DATA_WIDTH'(32'h0000_00FF);
            2'd1:    rd_mask = DATA_WIDTH'(32'h0000_FFFF);
            default: rd_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        endcase
    end

    // Byte strobes for the incoming request; no lane shifting by address
    always_comb begin
        req_stb = 4'b0000;
        case (req_size)
            2'd0:    req_stb = 4'b0001;
            2'd1:    req_stb = 4'b0011;
            2'd2:    req_stb = 4'b1111;
            default: req_stb = 4'b0000;
        endcase
    end

    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Transfer sequencer with registered APB and response outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= S_IDLE;
            size_q      <= 2'd0;
            tmo_cnt_q   <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pstb_q      <= 4'b0000;
            paddr_q     <= '0;
            pdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q <= req_size;
                        if (req_size == 2'd3) begin
                            // Illegal size: answer with an error, no bus cycle
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            paddr_q   <= req_addr;
                            pdata_q   <= req_wdata;
                            pwrite_q  <= req_we;
                            pstb_q    <= req_stb;
                            state_q   <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    tmo_cnt_q <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        // Completion wins over a coincident timeout
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_err_q   <= perr;
                        rsp_rdata_q <= pwrite_q ? '0 : (prdata & rd_mask);
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (tmo_hit) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign paddr     = paddr_q;
    assign pdata     = pdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pstb      = pstb_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_mem_bridge
// Description : Self-checking bench for apb_mem_bridge with an APB slave
//               model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_bridge;

    localparam int TMO = 8;

    logic        pclk;
    logic        presetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [31:0] prdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        pready;
    logic        perr;

    apb_mem_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pdata     (pdata),
        .prdata    (prdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pstb      (pstb),
        .pready    (pready),
        .perr      (perr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    // Slave configuration and expected bus fields
    int          slv_wait = 0;
    bit          slv_hang = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    logic [31:0] exp_paddr = '0;
    logic [31:0] exp_pdata = '0;
    logic        exp_pwrite = 1'b0;
    logic [3:0]  exp_pstb = '0;
    int          acc_cnt = 0;
    int          last_acc_len = 0;
    bit          psel_seen = 0;

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] size_stb(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // APB slave model: counts ACCESS cycles, checks bus stability, answers
    always @(negedge pclk) begin
        if (psel) psel_seen = 1;
        if (psel && penable) begin
            acc_cnt++;
            check("apb_paddr",  paddr, exp_paddr);
            check("apb_pdata",  pdata, exp_pdata);
            check("apb_pwrite", {31'd0, pwrite}, {31'd0, exp_pwrite});
            check("apb_pstb",   {28'd0, pstb}, {28'd0, exp_pstb});
            pready = !slv_hang && (acc_cnt > slv_wait);
            perr   = pready ? slv_err : 1'b0;
            prdata = pready ? slv_rdata : 32'hA5A5_5A5A;
        end else begin
            if (acc_cnt != 0) last_acc_len = acc_cnt;
            acc_cnt = 0;
            pready  = 1'b0;
            perr    = 1'b0;
            prdata  = 32'hC3C3_3C3C;
        end
    end

    // Response scoreboard: pop on each handshake
    always @(negedge pclk) begin
        if (presetn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [1:0] sz, input logic [31:0] srd, input logic serr);
        exp_t e;
        int   n;
        slv_rdata  = srd;
        slv_err    = serr;
        exp_paddr  = a;
        exp_pdata  = wd;
        exp_pwrite = we;
        exp_pstb   = size_stb(sz);
        if (sz == 2'd3 || slv_hang) begin
            e.rdata = 32'd0;
            e.err   = 1'b1;
        end else begin
            e.rdata = we ? 32'd0 : (srd & size_mask(sz));
            e.err   = serr;
        end
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge pclk); #1;
            n++;
        end
        if (!req_ready) check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        sb.push_back(e);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_we    = we;
        req_size  = sz;
        @(posedge pclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!(sb.size() == 0 && !rsp_valid) && n < 200) begin
            @(posedge pclk); #1;
            n++;
        end
        check("rsp_wait", sb.size(), 0);
    endtask

    initial begin
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        perr      = 1'b0;
        prdata    = '0;

        // Reset values
        repeat (3) @(posedge pclk);
        #1;
        check("rst_ctrl", {26'd0, psel, penable, pwrite, rsp_valid, rsp_err, req_ready}, 32'h1);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pdata", pdata, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_pstb", {28'd0, pstb}, 32'd0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // 1: word store, pready after 5 ACCESS cycles
        slv_wait = 4;
        do_req(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 2'd2, 32'h0, 1'b0);
        wait_rsp();
        check("store_acc_len", last_acc_len, 5);

        // 2: byte load with minimum-latency timing, then half and word loads
        slv_wait = 0;
        do_req(32'h0000_0013, 32'h0, 1'b0, 2'd0, 32'h1234_5678, 1'b0);
        check("lat_setup", {30'd0, psel, penable}, 32'h2);
        @(posedge pclk); #1;
        check("lat_access", {30'd0, psel, penable}, 32'h3);
        @(posedge pclk); #1;
        check("lat_rsp", {29'd0, rsp_valid, psel, penable}, 32'h4);
        wait_rsp();
        do_req(32'h0000_0012, 32'h0, 1'b0, 2'd1, 32'h1234_5678, 1'b0);
        wait_rsp();
        do_req(32'h0000_0010, 32'h0, 1'b0, 2'd2, 32'h1234_5678, 1'b0);
        wait_rsp();

        // 3: illegal size, no bus cycle
        psel_seen = 0;
        do_req(32'h0000_0020, 32'h1111_2222, 1'b0, 2'd3, 32'hFFFF_FFFF, 1'b0);
        wait_rsp();
        check("ill_no_psel", {31'd0, psel_seen}, 32'd0);

        // 4: timeout with pready held low, then normal transfer
        slv_hang = 1;
        do_req(32'h0000_0040, 32'h0, 1'b0, 2'd2, 32'h5555_AAAA, 1'b0);
        wait_rsp();
        check("tmo_acc_len", last_acc_len, TMO);
        slv_hang = 0;
        slv_wait = 2;
        do_req(32'h0000_0044, 32'h0, 1'b0, 2'd2, 32'h0BAD_F00D, 1'b0);
        wait_rsp();

        // 5: slave error, response held under backpressure
        rsp_ready = 1'b0;
        slv_wait  = 1;
        do_req(32'h0000_0050, 32'h0, 1'b0, 2'd1, 32'hCAFE_8001, 1'b1);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 50) begin
                @(posedge pclk); #1;
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, 32'h0000_8001);
            check("hold_err", {31'd0, rsp_err}, 32'd1);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge pclk); #1;
        end
        rsp_ready = 1'b1;
        wait_rsp();

        // Mixed traffic
        for (int i = 0; i < 6; i++) begin
            slv_wait = int'($urandom_range(0, 3));
            do_req($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   $urandom, 1'($urandom_range(0, 1)));
            wait_rsp();
        end

        // 6: reset during ACCESS drops the transfer
        slv_hang = 1;
        do_req(32'h0000_0060, 32'h0, 1'b0, 2'd2, 32'h7777_7777, 1'b0);
        sb.delete();
        begin
            int n;
            n = 0;
            while (!penable && n < 20) begin
                @(posedge pclk); #1;
                n++;
            end
        end
        check("pre_rst_penable", {31'd0, penable}, 32'd1);
        #2;
        presetn = 1'b0;
        #1;
        check("midrst_outputs", {29'd0, psel, penable, rsp_valid}, 32'd0);
        @(posedge pclk); #1;
        presetn  = 1'b1;
        slv_hang = 0;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        begin
            bit stale;
            stale = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge pclk); #1;
                if (rsp_valid) stale = 1;
            end
            check("midrst_no_stale", {31'd0, stale}, 32'd0);
        end
        slv_wait = 0;
        do_req(32'h0000_0064, 32'h0, 1'b0, 2'd0, 32'h0000_00EE, 1'b0);
        wait_rsp();

        repeat (3) @(posedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
